// File: rtl/fuzz_pack_pipe.sv
// Elastic pipelined field-packing fuzz block: five W-bit words -> packed 3W+1 result.
// Optional running XOR signature / output counter enabled by FUZZ_PACK_SIG_EN.
module fuzz_pack_pipe #(
  parameter int unsigned W      = 11,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] wire0,
  input  logic [W-1:0] wire1,
  input  logic [W-1:0] wire2,
  input  logic [W-1:0] wire3,
  input  logic [W-1:0] wire4,
  output logic [3*W:0] y,
  output logic         out_valid,
  input  logic         out_ready
`ifdef FUZZ_PACK_SIG_EN
  ,
  output logic [3*W:0] sig,
  output logic [15:0]  sig_cnt
`endif
);

  logic [W-1:0]     f5;
  logic [W-1:0]     f6;
  logic [1:0]       f7;
  logic             f8;
  logic [W-4:0]     f9;
  logic             cond;
  logic [3*W:0]     packed_y;

  logic [3*W:0]     data [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] load;
  logic             drain;
  logic             accept;

  always_comb begin
    f5   = W'(wire3[W-1:3]);
    cond = |(wire4 | (wire1 ^ wire0));
    if (cond)
      f6 = f5 ~^ wire1;
    else if (wire0[W-2])
      f6 = wire1;
    else
      f6 = W'(7'h40);
    f7       = f5[3:2] >> (|wire2);
    f8       = ~|f5;
    f9       = f5[W-1:3];
    packed_y = {f9, f8, f7, f6, f5, 1'b0};
  end

  // ready[k] unrolled as "some later stage is empty, or the output drains",
  // so the chain is a running OR rather than a self-referencing vector.
  always_comb begin
    drain               = out_ready;
    ready               = '0;
    ready[STAGES-1]     = out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      drain               = drain || !v[STAGES-i];
      ready[STAGES-1-i]   = drain;
    end
    load = ~v | ready;
  end

  assign in_ready  = load[0] && !rst;
  assign accept    = in_valid && in_ready;
  assign y         = data[STAGES-1];
  assign out_valid = v[STAGES-1];

  // Data registers only move when a valid item arrives, so bubbles never
  // overwrite the last delivered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int unsigned i = 0; i < STAGES; i++)
        data[i] <= '0;
    end else begin
      if (load[0]) begin
        v[0] <= accept;
        if (accept)
          data[0] <= packed_y;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          v[i] <= v[i-1];
          if (v[i-1])
            data[i] <= data[i-1];
        end
      end
    end
  end

`ifdef FUZZ_PACK_SIG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sig     <= '0;
      sig_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sig     <= sig ^ y;
      sig_cnt <= sig_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fuzz_pack_pipe.sv
// Directed self-checking bench for fuzz_pack_pipe at W=11, STAGES=2.
// Signature checks are compiled in when FUZZ_PACK_SIG_EN is defined.
module tb_fuzz_pack_pipe;
  localparam int W      = 11;
  localparam int STAGES = 2;
  localparam int YW     = 3*W+1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  wire0 = '0, wire1 = '0, wire2 = '0, wire3 = '0, wire4 = '0;
  logic [YW-1:0] y;
`ifdef FUZZ_PACK_SIG_EN
  logic [YW-1:0] sig;
  logic [15:0]   sig_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]  bw0 [4];
  logic [W-1:0]  bw1 [4];
  logic [W-1:0]  bw2 [4];
  logic [W-1:0]  bw3 [4];
  logic [W-1:0]  bw4 [4];
  logic [YW-1:0] by  [4];

  always #5 clk = ~clk;

  fuzz_pack_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3), .wire4(wire4),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FUZZ_PACK_SIG_EN
    , .sig(sig), .sig_cnt(sig_cnt)
`endif
  );

  task automatic set_beat(input int i);
    wire0 = bw0[i]; wire1 = bw1[i]; wire2 = bw2[i]; wire3 = bw3[i]; wire4 = bw4[i];
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (y !== '0) begin miscompares++; $display("FAIL reset_y: got %h expected 0", y); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_packing(input string name, input logic [W-1:0] a0, a1, a2, a3, a4,
                              input logic [YW-1:0] exp);
    @(posedge clk); #1;
    wire0 = a0; wire1 = a1; wire2 = a2; wire3 = a3; wire4 = a4;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early_valid: got %b expected 0", name, out_valid); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid); end
    vectors++; if (y !== exp) begin miscompares++; $display("FAIL %s_y: got %h expected %h", name, y, exp); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_duplicate: got %b expected 0", name, out_valid); end
  endtask

  task automatic test_back_pressure;
    int idx = 0;
    int got = 0;
    bit acc;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; set_beat(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      set_beat(idx);
    end
    vectors++; if (idx !== 2) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    vectors++; if (y !== by[0]) begin miscompares++; $display("FAIL bp_y_hold: got %h expected %h", y, by[0]); end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_rise: got %b expected 1", in_ready); end
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        vectors++;
        if (y !== by[got]) begin miscompares++; $display("FAIL bp_order_%0d: got %h expected %h", got, y, by[got]); end
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 4) set_beat(idx); else in_valid = 1'b0;
    end
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_drained: got %0d expected 4", got); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_extra_output: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    bit stale = 1'b0;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; set_beat(1);
    @(posedge clk); #1; set_beat(2);
    @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1; set_beat(3);
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_in_ready_during: got %b expected 0", in_ready); end
    @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    vectors++; if (y !== '0) begin miscompares++; $display("FAIL rstmid_y: got %h expected 0", y); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready_after: got %b expected 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale: got %b expected 0", stale); end
  endtask

  task automatic test_back_to_back;
    int idx = 0, got = 0, first = -1, last = -1;
    bit acc;
    @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b1; set_beat(0);
    for (int c = 0; c < 16 && got < 4; c++) begin
      @(negedge clk);
      if (in_valid) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready_%0d: got %b expected 1", c, in_ready); end
      end
      if (out_valid) begin
        vectors++;
        if (y !== by[got]) begin miscompares++; $display("FAIL b2b_y_%0d: got %h expected %h", got, y, by[got]); end
        if (got == 0) first = c;
        last = c;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 4) set_beat(idx); else in_valid = 1'b0;
    end
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", got); end
    vectors++; if (last - first !== 3) begin miscompares++; $display("FAIL b2b_gapless: got span %0d expected 3", last - first); end
    vectors++; if (first !== 2) begin miscompares++; $display("FAIL b2b_latency: got first at %0d expected 2", first); end
  endtask

`ifdef FUZZ_PACK_SIG_EN
  task automatic test_signature;
    int idx = 0, got = 0, n, c;
    bit acc;
    logic [YW-1:0] exp_sig;
    @(posedge clk); #1; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    vectors++; if (sig !== '0) begin miscompares++; $display("FAIL sig_reset: got %h expected 0", sig); end
    vectors++; if (sig_cnt !== 16'd0) begin miscompares++; $display("FAIL sig_cnt_reset: got %h expected 0", sig_cnt); end
    @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b1; set_beat(0);
    for (int k = 0; k < 16 && got < 3; k++) begin
      @(negedge clk);
      if (out_valid) got++;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 3) set_beat(idx); else in_valid = 1'b0;
    end
    exp_sig = by[0] ^ by[1] ^ by[2];
    @(negedge clk);
    vectors++; if (sig !== exp_sig) begin miscompares++; $display("FAIL sig_xor3: got %h expected %h", sig, exp_sig); end
    vectors++; if (sig_cnt !== 16'd3) begin miscompares++; $display("FAIL sig_cnt3: got %h expected 3", sig_cnt); end
    @(posedge clk); #1; in_valid = 1'b1; set_beat(0);
    n = 3; c = 0;
    while (n < 65535 && c < 70000) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (sig_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sig_cnt_max: got %h expected ffff", sig_cnt); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sig_pending: got %b expected 1", out_valid); end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    vectors++; if (sig_cnt !== 16'h0000) begin miscompares++; $display("FAIL sig_cnt_wrap: got %h expected 0", sig_cnt); end
  endtask
`endif

  initial begin
    // y = {f9, f8, f7, f6, f5, 0}; f9 = f5[10:3]
    bw0[0] = 11'h000; bw1[0] = 11'h000; bw2[0] = 11'h000; bw3[0] = 11'h7F8; bw4[0] = 11'h000; by[0] = 34'h07D8401FE;
    bw0[1] = 11'h000; bw1[1] = 11'h000; bw2[1] = 11'h000; bw3[1] = 11'h0A8; bw4[1] = 11'h000; by[1] = 34'h00884002A;
    bw0[2] = 11'h200; bw1[2] = 11'h200; bw2[2] = 11'h000; bw3[2] = 11'h400; bw4[2] = 11'h000; by[2] = 34'h040200100;
    bw0[3] = 11'h000; bw1[3] = 11'h000; bw2[3] = 11'h000; bw3[3] = 11'h007; bw4[3] = 11'h000; by[3] = 34'h002040000;

    test_reset();
    test_packing("basic", 11'h000, 11'h000, 11'h000, 11'h7F8, 11'h000, 34'h07D8401FE);
    test_packing("cond1", 11'h000, 11'h005, 11'h001, 11'h7F8, 11'h001, 34'h07CF051FE);
    test_packing("zero",  11'h000, 11'h000, 11'h000, 11'h007, 11'h000, 34'h002040000);
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
`ifdef FUZZ_PACK_SIG_EN
    test_signature();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
